// File: rtl/midi_event_decoder.sv
// MIDI event decoder: turns the UART byte stream into one-cycle note events
// with note/velocity/channel fields, tracking running status and a
// diagnostic read-back Control Change.
module midi_event_decoder #(
  parameter logic [6:0] RB_CC = 7'h66
) (
  input  logic       clk32,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       note_pressed,
  output logic       note_released,
  output logic       note_keypress,
  output logic       note_channelpress,
  output logic       read_back,
  output logic [6:0] note_interface,
  output logic [6:0] velocity,
  output logic [3:0] channel,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;
  typedef enum logic [1:0] {ST_NONE, ST_SYS, ST_CHAN} kind_t;

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic       pressed_q, pressed_d;
  logic       released_q, released_d;
  logic       keypress_q, keypress_d;
  logic       chanpress_q, chanpress_d;
  logic       read_back_q, read_back_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic [3:0] chan_q, chan_d;
  logic [7:0] err_q, err_d;

  // Message completion request, with the two data bytes of the message
  logic       cmp;
  logic [6:0] cd1, cd2;

  // Byte classification, FSM next state and event decode
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    status_d    = status_q;
    d1_d        = d1_q;
    pressed_d   = 1'b0;
    released_d  = 1'b0;
    keypress_d  = 1'b0;
    chanpress_d = 1'b0;
    read_back_d = 1'b0;
    note_d      = note_q;
    vel_d       = vel_q;
    chan_d      = chan_q;
    err_d       = err_q;
    cmp         = 1'b0;
    cd1         = d1_q;
    cd2         = 7'd0;

    if (rx_valid) begin
      if (rx_data[7:4] == 4'hF) begin
        // 0xF8-0xFF are realtime and leave everything untouched
        if (!rx_data[3]) begin
          state_d = IDLE;
          kind_d  = (rx_data[2:0] == 3'd0) ? ST_SYS : ST_NONE;
        end
      end else if (rx_data[7]) begin
        // New channel status abandons any partial message silently
        status_d = rx_data;
        kind_d   = ST_CHAN;
        state_d  = WAIT_D1;
      end else begin
        case (state_q)
          IDLE: begin
            if (kind_q == ST_NONE && err_q != 8'hFF) err_d = err_q + 8'd1;
          end
          WAIT_D1: begin
            d1_d = rx_data[6:0];
            cd1  = rx_data[6:0];
            if (status_q[7:4] == 4'hC || status_q[7:4] == 4'hD) begin
              cmp     = 1'b1;
              state_d = WAIT_D1;
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            cmp     = 1'b1;
            cd2     = rx_data[6:0];
            state_d = WAIT_D1;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    if (cmp) begin
      case (status_q[7:4])
        4'h8, 4'h9, 4'hA: begin
          if (status_q[7:4] == 4'hA)      keypress_d = 1'b1;
          else if (status_q[7:4] == 4'h9 && cd2 != 7'd0) pressed_d = 1'b1;
          else                             released_d = 1'b1;
          note_d = cd1;
          vel_d  = cd2;
          chan_d = status_q[3:0];
        end
        4'hD: begin
          chanpress_d = 1'b1;
          vel_d       = cd1;
          chan_d      = status_q[3:0];
        end
        4'hB: begin
          if (cd1 == RB_CC) begin
            read_back_d = 1'b1;
            vel_d       = cd2;
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs; everything clears while reset is low
  always_ff @(posedge clk32 or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      kind_q      <= ST_NONE;
      status_q    <= 8'd0;
      d1_q        <= 7'd0;
      pressed_q   <= 1'b0;
      released_q  <= 1'b0;
      keypress_q  <= 1'b0;
      chanpress_q <= 1'b0;
      read_back_q <= 1'b0;
      note_q      <= 7'd0;
      vel_q       <= 7'd0;
      chan_q      <= 4'd0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      status_q    <= status_d;
      d1_q        <= d1_d;
      pressed_q   <= pressed_d;
      released_q  <= released_d;
      keypress_q  <= keypress_d;
      chanpress_q <= chanpress_d;
      read_back_q <= read_back_d;
      note_q      <= note_d;
      vel_q       <= vel_d;
      chan_q      <= chan_d;
      err_q       <= err_d;
    end
  end

  assign note_pressed      = pressed_q;
  assign note_released     = released_q;
  assign note_keypress     = keypress_q;
  assign note_channelpress = chanpress_q;
  assign read_back         = read_back_q;
  assign note_interface    = note_q;
  assign velocity          = vel_q;
  assign channel           = chan_q;
  assign err_count         = err_q;

endmodule

// File: tb/tb_midi_event_decoder.sv
// Testbench for midi_event_decoder: directed byte sequences, expected events
// queued by the stimulus and checked by an independent output monitor.
module tb_midi_event_decoder;

  logic       clk32 = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       note_pressed, note_released, note_keypress, note_channelpress, read_back;
  logic [6:0] note_interface, velocity;
  logic [3:0] channel;
  logic [7:0] err_count;

  midi_event_decoder #(.RB_CC(7'h66)) dut (
    .clk32(clk32), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .note_pressed(note_pressed), .note_released(note_released),
    .note_keypress(note_keypress), .note_channelpress(note_channelpress),
    .read_back(read_back), .note_interface(note_interface),
    .velocity(velocity), .channel(channel), .err_count(err_count)
  );

  always #5 clk32 = ~clk32;

  // Pulse vector order: pressed, released, keypress, channelpress, read_back
  localparam logic [4:0] P_ON = 5'b10000, P_OFF = 5'b01000, P_KEY = 5'b00100,
                         P_CH = 5'b00010, P_RB = 5'b00001;

  typedef struct {
    logic [4:0] pulses;
    logic [6:0] note;
    logic [6:0] vel;
    logic [3:0] ch;
    int         cyc;
  } ev_t;

  ev_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;

  always @(posedge clk32) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One byte per cycle; returns just after the edge that captured it
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk32);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_ev(input logic [4:0] p, input logic [6:0] n,
                           input logic [6:0] v, input logic [3:0] c);
    ev_t e;
    e.pulses = p; e.note = n; e.vel = v; e.ch = c; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk32);
    #1;
  endtask

  task automatic do_reset;
    #2 rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(1);
  endtask

  // Monitor: any pulse must match the next queued event, on the expected cycle
  always @(negedge clk32) begin
    logic [4:0] p;
    ev_t e;
    p = {note_pressed, note_released, note_keypress, note_channelpress, read_back};
    if (p != 5'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", int'(p), 0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", int'(p), int'(e.pulses));
        chk("note_interface", int'(note_interface), int'(e.note));
        chk("velocity", int'(velocity), int'(e.vel));
        chk("channel", int'(channel), int'(e.ch));
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    // Reset state
    idle(2);
    chk("rst_pulses", int'({note_pressed, note_released, note_keypress, note_channelpress, read_back}), 0);
    chk("rst_fields", int'({note_interface, velocity, channel}), 0);
    chk("rst_err", int'(err_count), 0);
    rst = 1'b1;
    idle(1);

    // Basic Note On
    send(8'h93); send(8'h3C); send(8'h64); expect_ev(P_ON, 7'h3C, 7'h64, 4'h3);
    idle(2);

    // Running status, Note On with velocity 0 is a release
    send(8'h90); send(8'h40); send(8'h50); expect_ev(P_ON, 7'h40, 7'h50, 4'h0);
    send(8'h40); send(8'h00); expect_ev(P_OFF, 7'h40, 7'h00, 4'h0);
    idle(2);

    // Realtime byte between data bytes
    send(8'h91); send(8'h3C); send(8'hF8); send(8'h7F); expect_ev(P_ON, 7'h3C, 7'h7F, 4'h1);
    idle(2);

    // Read-back CC, then an ordinary CC that must not disturb the fields
    send(8'hB0); send(8'h66); send(8'h01); expect_ev(P_RB, 7'h3C, 7'h01, 4'h1);
    send(8'hB0); send(8'h07); send(8'h10);
    idle(2);
    chk("cc_vel_hold", int'(velocity), 8'h01);
    chk("cc_note_hold", int'(note_interface), 8'h3C);

    // Note Off, key pressure, and silent program change / pitch bend
    send(8'h85); send(8'h20); send(8'h30); expect_ev(P_OFF, 7'h20, 7'h30, 4'h5);
    send(8'hA7); send(8'h11); send(8'h22); expect_ev(P_KEY, 7'h11, 7'h22, 4'h7);
    send(8'hC0); send(8'h05); send(8'h06);
    send(8'hE1); send(8'h00); send(8'h40);
    idle(2);
    chk("no_orphans_yet", int'(err_count), 0);
    chk("silent_msgs_hold_vel", int'(velocity), 8'h22);

    // SysEx data is discarded; a data byte after 0xF7 is an orphan
    do_reset();
    send(8'hF0); send(8'h01); send(8'h02);
    idle(1);
    chk("sysex_no_err", int'(err_count), 0);
    send(8'hF7); send(8'h05);
    idle(1);
    chk("post_sysex_orphan", int'(err_count), 1);

    // Orphan saturation
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(8'h3C);
      if (i == 99) chk("err_100", int'(err_count), 100);
    end
    idle(1);
    chk("err_saturated", int'(err_count), 8'hFF);
    send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h05);
    idle(1);
    chk("err_stays_sat", int'(err_count), 8'hFF);

    // Channel pressure, then reset mid-message
    do_reset();
    send(8'hD2); send(8'h30); expect_ev(P_CH, 7'h00, 7'h30, 4'h2);
    idle(2);
    send(8'h92);
    #2 rst = 1'b0;
    #1;
    chk("async_clear_vel", int'(velocity), 0);
    chk("async_clear_ch", int'(channel), 0);
    idle(2);
    rst = 1'b1;
    idle(1);
    send(8'h3C);
    idle(2);
    chk("orphan_after_reset", int'(err_count), 1);

    idle(3);
    chk("events_outstanding", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/midi_event_decoder.md
Name: midi_event_decoder

Overview:
- Converts the byte stream from the MIDI UART receiver into single-cycle note events for the synth voice controller.
- Produces the note_pressed / note_released / note_keypress / note_channelpress pulses, with note, velocity and channel fields valid in the same cycle, so the synth can push each event straight into its command FIFO.
- Tracks running status and decodes a diagnostic read-back command (Control Change on a reserved controller number).
- Sits between the UART receiver and synth2.

Parameters:
- RB_CC, 7'h66, controller number whose Control Change generates a read_back pulse.

Ports:
- clk32  in  1  system clock, 32 MHz.
- rst  in  1  reset, asynchronous, active-low; all flops clear while low.
- rx_data  in  8  received byte from the UART; valid when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- note_pressed  out  1  one-cycle pulse: Note On, velocity≠0.
- note_released  out  1  one-cycle pulse: Note Off, or Note On with velocity 0.
- note_keypress  out  1  one-cycle pulse: Polyphonic Key Pressure.
- note_channelpress  out  1  one-cycle pulse: Channel Pressure.
- read_back  out  1  one-cycle pulse: CC controller==RB_CC.
- note_interface  out  7  note number of the last event (first data byte).
- velocity  out  7  velocity / pressure / CC value of the last event.
- channel  out  4  MIDI channel of the last event.
- err_count  out  8  saturating count of orphan data bytes.

Behaviour:
- Reset (rst=0, async):
  - All pulse outputs are 0.
  - note_interface, velocity and channel are 0.
  - err_count is 0.
  - Running status is cleared (status=none) and the FSM is in IDLE.
- Byte classes, applied when rx_valid=1:
  - Realtime (0xF8–0xFF): ignored entirely. State, running status and the latched data byte are all untouched, including between data bytes.
  - System common / SysEx (0xF0–0xF7): clears running status; FSM → IDLE. Data bytes that follow are discarded and do not count as errors while status=sys. Status is set to sys by 0xF0 and cleared to none by 0xF7 or by any other status byte.
  - Channel status (0x80–0xEF): latch status[7:0]; FSM → WAIT_D1. Any partially received message is abandoned, with no pulse and no error.
  - Data (bit7=0): handled per the FSM below.
- Message length:
  - Two data bytes: 0x8n, 0x9n, 0xAn, 0xBn, 0xEn.
  - One data byte: 0xCn, 0xDn.
- FSM states: IDLE, WAIT_D1, WAIT_D2.
  - IDLE + data byte:
    - status=none: err_count += 1 (saturates at 8'hFF); byte dropped.
    - status=sys: byte dropped silently.
  - WAIT_D1 + data byte:
    - Latch it as d1.
    - Two-byte status → WAIT_D2.
    - One-byte status → complete the message with d2=0, → WAIT_D1 (running status).
  - WAIT_D2 + data byte: complete the message with d1 and this byte, → WAIT_D1 (running status).
- Message completion, registered: outputs update on the clock edge after the completing rx_valid cycle (latency 1 cycle).
  - 0x9n, d2≠0: note_pressed=1; note_interface=d1; velocity=d2; channel=n.
  - 0x9n, d2=0, and 0x8n: note_released=1; same field loading (velocity=d2).
  - 0xAn: note_keypress=1; fields loaded.
  - 0xDn: note_channelpress=1; note_interface unchanged; velocity=d1; channel=n.
  - 0xBn, d1==RB_CC: read_back=1; velocity=d2 (read-back select); note_interface and channel unchanged.
  - 0xBn with another controller, 0xCn, 0xEn: no pulse; fields unchanged.
- Pulse and field timing:
  - Every pulse is high for exactly one cycle.
  - At most one pulse is high in any cycle.
  - Fields hold their value until the next completed event. The fields and the pulse change on the same edge.
- rx_valid=0: the FSM and all registers hold. Back-to-back rx_valid on consecutive cycles is supported (one byte per cycle).
- Reset asserted mid-message: the partial message is lost, and after release a data byte counts as an orphan.

Test Plan:
- 0x93,0x3C,0x64 → one cycle after the last byte: note_pressed=1 for 1 cycle; note_interface=0x3C, velocity=0x64, channel=3.
- Running status 0x90,0x40,0x50,0x40,0x00 → note_pressed (0x40/0x50), then note_released (0x40, velocity=0); channel=0 for both.
- 0x91,0x3C,0xF8,0x7F → realtime byte ignored; note_pressed with note 0x3C, velocity 0x7F.
- 0xB0,0x66,0x01 → read_back pulse; velocity=0x01. Then 0xB0,0x07,0x10 → no pulse; velocity stays 0x01.
- After reset, send 0x3C 300 times → err_count saturates at 0xFF and no pulses occur. Then 0xF0,0x01,0x02,0xF7,0x05 → err_count stays 0xFF; the trailing 0x05 (status=none) is an orphan and saturates.
- 0xD2,0x30 → note_channelpress, velocity=0x30, channel=2. Pull rst low between 0x92 and its data byte → outputs clear immediately; the following 0x3C counts as an orphan (err_count=1).
